// File: rtl/coax_rx_sequencer.sv
// Frames coax_rx words into EOF-tagged messages and in-band error words, buffered in a FWFT FIFO.
// Latency: a word is pushed on the next strobe or at frame end and is visible one cycle later; an error word is visible 2 cycles after rx_error.
// Backpressure: none toward coax_rx; a push while full is dropped and sets sticky overflow. Optional counter: COAX_RX_SEQUENCER_FRAME_COUNT_EN.
module coax_rx_sequencer #(
  parameter int DEPTH        = 16,
  parameter int GUARD_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        rx_active,
  input  logic        rx_strobe,
  input  logic        rx_error,
  input  logic [9:0]  rx_data,
  output logic        rx_reset,
  input  logic        rd_en,
  output logic [11:0] rd_data,
  output logic        empty,
  output logic        full,
  output logic        overflow,
  input  logic        clr_overflow,
  output logic [7:0]  frame_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [7:0] GUARD_LOAD = 8'(GUARD_CYCLES);

  typedef enum logic [2:0] {DISABLED, IDLE, RECEIVING, ERROR, GUARD} state_t;
  typedef struct packed {
    logic       err;
    logic       eof;
    logic [9:0] dat;
  } word_t;

  state_t     state;
  logic       pend_vld;
  logic [9:0] pend_dat;
  logic [9:0] err_code;
  logic [7:0] guard_cnt;

  word_t push_dat;
  logic  push_vld;

  // Held word is only released once we know whether it ends the frame.
  always_comb begin
    push_vld     = 1'b0;
    push_dat.err = 1'b0;
    push_dat.eof = 1'b0;
    push_dat.dat = pend_dat;
    if (enable) begin
      case (state)
        RECEIVING: begin
          if (rx_error || rx_strobe) begin
            push_vld = pend_vld;
          end else if (!rx_active) begin
            push_vld     = pend_vld;
            push_dat.eof = 1'b1;
          end
        end
        ERROR: begin
          push_vld     = 1'b1;
          push_dat.err = 1'b1;
          push_dat.eof = 1'b1;
          push_dat.dat = err_code;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= DISABLED;
      rx_reset  <= 1'b1;
      pend_vld  <= 1'b0;
      pend_dat  <= '0;
      err_code  <= '0;
      guard_cnt <= '0;
    end else if (!enable) begin
      state     <= DISABLED;
      rx_reset  <= 1'b1;
      pend_vld  <= 1'b0;
      guard_cnt <= '0;
    end else begin
      case (state)
        DISABLED: begin
          state    <= IDLE;
          rx_reset <= 1'b0;
        end
        IDLE: begin
          if (rx_error) begin
            state    <= ERROR;
            err_code <= rx_data;
            rx_reset <= 1'b1;
          end else if (rx_active) begin
            state <= RECEIVING;
          end
        end
        RECEIVING: begin
          if (rx_error) begin
            state    <= ERROR;
            err_code <= rx_data;
            rx_reset <= 1'b1;
            pend_vld <= 1'b0;
          end else if (rx_strobe) begin
            pend_dat <= rx_data;
            pend_vld <= 1'b1;
          end else if (!rx_active) begin
            state    <= IDLE;
            pend_vld <= 1'b0;
          end
        end
        ERROR: begin
          state     <= GUARD;
          rx_reset  <= 1'b0;
          guard_cnt <= GUARD_LOAD;
        end
        GUARD: begin
          // Any line activity means the link is not yet quiet: start over.
          if (rx_active) begin
            guard_cnt <= GUARD_LOAD;
          end else if (guard_cnt <= 8'd1) begin
            guard_cnt <= '0;
            state     <= IDLE;
          end else begin
            guard_cnt <= guard_cnt - 8'd1;
          end
        end
        default: begin
          state    <= DISABLED;
          rx_reset <= 1'b1;
        end
      endcase
    end
  end

  logic [AW:0] wptr, rptr, wptr_nx, rptr_nx;
  word_t       mem [DEPTH];
  word_t       head_nx;
  logic        pop, push_acc;

  always_comb begin
    pop      = rd_en && !empty;
    push_acc = push_vld && (!full || pop);
    wptr_nx  = wptr + (AW+1)'(push_acc);
    rptr_nx  = rptr + (AW+1)'(pop);
    // Bypass when the next head is the slot being written this cycle.
    if (push_acc && (rptr_nx == wptr)) head_nx = push_dat;
    else                               head_nx = mem[rptr_nx[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem[wptr[AW-1:0]] <= push_dat;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      empty    <= 1'b1;
      full     <= 1'b0;
      overflow <= 1'b0;
      rd_data  <= '0;
    end else begin
      wptr     <= wptr_nx;
      rptr     <= rptr_nx;
      empty    <= (wptr_nx == rptr_nx);
      full     <= (wptr_nx[AW] != rptr_nx[AW]) && (wptr_nx[AW-1:0] == rptr_nx[AW-1:0]);
      overflow <= (push_vld && full && !pop) || (overflow && !clr_overflow);
      if (wptr_nx != rptr_nx) rd_data <= head_nx;
    end
  end

`ifdef COAX_RX_SEQUENCER_FRAME_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count <= '0;
    end else if (push_acc && push_dat.eof && !push_dat.err) begin
      frame_count <= frame_count + 8'd1;
    end
  end
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_coax_rx_sequencer.sv
// Directed bench for coax_rx_sequencer with DEPTH=4, GUARD_CYCLES=8.
module tb_coax_rx_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        rx_active = 1'b0;
  logic        rx_strobe = 1'b0;
  logic        rx_error = 1'b0;
  logic [9:0]  rx_data = '0;
  logic        rd_en = 1'b0;
  logic        clr_overflow = 1'b0;
  logic        rx_reset, empty, full, overflow;
  logic [11:0] rd_data;
  logic [7:0]  frame_count;

  int checks = 0;
  int errors = 0;
  logic [7:0] fc_good = '0;

  always #5 clk = ~clk;

  coax_rx_sequencer #(.DEPTH(4), .GUARD_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rx_active(rx_active),
    .rx_strobe(rx_strobe), .rx_error(rx_error), .rx_data(rx_data),
    .rx_reset(rx_reset), .rd_en(rd_en), .rd_data(rd_data), .empty(empty),
    .full(full), .overflow(overflow), .clr_overflow(clr_overflow),
    .frame_count(frame_count)
  );

  function automatic logic [7:0] fc_model();
`ifdef COAX_RX_SEQUENCER_FRAME_COUNT_EN
    return fc_good;
`else
    return 8'd0;
`endif
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop1();
    rd_en = 1'b1; cyc(1); rd_en = 1'b0;
  endtask

  task automatic frame1(input logic [9:0] w);
    rx_active = 1'b1; cyc(1);
    rx_strobe = 1'b1; rx_data = w; cyc(1);
    rx_strobe = 1'b0; rx_active = 1'b0; cyc(1);
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    cyc(2);
    checks++; if (rx_reset !== 1'b1) begin errors++; $display("FAIL rst_rx_reset got %b exp 1", rx_reset); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL rst_flags got full=%b ovf=%b exp 0 0", full, overflow); end
    checks++; if (rd_data !== 12'h000) begin errors++; $display("FAIL rst_rd_data got %h exp 000", rd_data); end
    checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL rst_frame_count got %0d exp 0", frame_count); end
    reset = 1'b0; enable = 1'b1; cyc(1);
    checks++; if (rx_reset !== 1'b0) begin errors++; $display("FAIL enable_rx_reset got %b exp 0", rx_reset); end
  endtask

  task automatic test_frame();
    logic [11:0] exp [3];
    exp[0] = 12'h2B3; exp[1] = 12'h001; exp[2] = 12'h7FF;
    rx_active = 1'b1; cyc(1);
    rx_strobe = 1'b1; rx_data = 10'h2B3; cyc(1);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL frame_pending_hidden got empty=%b exp 1", empty); end
    rx_data = 10'h001; cyc(1);
    checks++; if (empty !== 1'b0 || rd_data !== 12'h2B3) begin errors++; $display("FAIL frame_first_push got %b/%h exp 0/2B3", empty, rd_data); end
    rx_data = 10'h3FF; cyc(1);
    rx_strobe = 1'b0; rx_active = 1'b0; cyc(1);
    fc_good++;
    checks++; if (frame_count !== fc_model()) begin errors++; $display("FAIL frame_count got %0d exp %0d", frame_count, fc_model()); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (empty !== 1'b0 || rd_data !== exp[i]) begin errors++; $display("FAIL frame_word%0d got %b/%h exp 0/%h", i, empty, rd_data, exp[i]); end
      pop1();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL frame_drained got empty=%b exp 1", empty); end
  endtask

  task automatic test_error_guard();
    logic [11:0] exp [4];
    exp[0] = 12'h155; exp[1] = 12'hC02; exp[2] = 12'hFFF; exp[3] = 12'hCAA;
    rx_active = 1'b1; cyc(1);
    rx_strobe = 1'b1; rx_data = 10'h155; cyc(1);
    rx_strobe = 1'b0; cyc(1);
    rx_error = 1'b1; rx_data = 10'h002; rx_active = 1'b0; cyc(1);
    checks++; if (rx_reset !== 1'b1) begin errors++; $display("FAIL err_rx_reset_pulse got %b exp 1", rx_reset); end
    checks++; if (empty !== 1'b0 || rd_data !== 12'h155) begin errors++; $display("FAIL err_pending_push got %b/%h exp 0/155", empty, rd_data); end
    rx_error = 1'b0; cyc(1);
    checks++; if (rx_reset !== 1'b0) begin errors++; $display("FAIL err_rx_reset_end got %b exp 0", rx_reset); end
    cyc(7);
    rx_error = 1'b1; rx_data = 10'h3FF; cyc(1);
    checks++; if (rx_reset !== 1'b0) begin errors++; $display("FAIL guard_too_short got rx_reset=%b exp 0", rx_reset); end
    cyc(1);
    checks++; if (rx_reset !== 1'b1) begin errors++; $display("FAIL guard_idle_return got rx_reset=%b exp 1", rx_reset); end
    rx_error = 1'b0; cyc(1);
    cyc(2);
    rx_active = 1'b1; cyc(1);
    rx_active = 1'b0; cyc(7);
    rx_error = 1'b1; rx_data = 10'h0AA; cyc(1);
    checks++; if (rx_reset !== 1'b0) begin errors++; $display("FAIL guard_restart got rx_reset=%b exp 0", rx_reset); end
    cyc(1);
    checks++; if (rx_reset !== 1'b1) begin errors++; $display("FAIL guard_restart_end got rx_reset=%b exp 1", rx_reset); end
    rx_error = 1'b0; cyc(12);
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL err_full got %b exp 1", full); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (empty !== 1'b0 || rd_data !== exp[i]) begin errors++; $display("FAIL err_word%0d got %b/%h exp 0/%h", i, empty, rd_data, exp[i]); end
      pop1();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL err_drained got empty=%b exp 1", empty); end
  endtask

  task automatic test_overflow();
    logic [11:0] exp [4];
    exp[0] = 12'h411; exp[1] = 12'h412; exp[2] = 12'h413; exp[3] = 12'h4F0;
    for (int i = 0; i < 6; i++) frame1(10'h010 + 10'(i));
    fc_good = fc_good + 8'd4;
    checks++; if (full !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_flags got full=%b ovf=%b exp 1 1", full, overflow); end
    checks++; if (rd_data !== 12'h410) begin errors++; $display("FAIL ovf_head got %h exp 410", rd_data); end
    checks++; if (frame_count !== fc_model()) begin errors++; $display("FAIL ovf_frame_count got %0d exp %0d", frame_count, fc_model()); end
    clr_overflow = 1'b1; cyc(1); clr_overflow = 1'b0;
    checks++; if (overflow !== 1'b0 || full !== 1'b1) begin errors++; $display("FAIL ovf_clear got ovf=%b full=%b exp 0 1", overflow, full); end
    rx_active = 1'b1; cyc(1);
    rx_strobe = 1'b1; rx_data = 10'h0F0; cyc(1);
    rx_strobe = 1'b0; rx_active = 1'b0; rd_en = 1'b1; cyc(1);
    rd_en = 1'b0; fc_good++;
    checks++; if (full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_pushpop got full=%b ovf=%b exp 1 0", full, overflow); end
    checks++; if (frame_count !== fc_model()) begin errors++; $display("FAIL ovf_pushpop_count got %0d exp %0d", frame_count, fc_model()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (empty !== 1'b0 || rd_data !== exp[i]) begin errors++; $display("FAIL ovf_word%0d got %b/%h exp 0/%h", i, empty, rd_data, exp[i]); end
      pop1();
    end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_drained got empty=%b exp 1", empty); end
  endtask

  task automatic test_enable_drop();
    rx_active = 1'b1; cyc(1);
    rx_strobe = 1'b1; rx_data = 10'h0A1; cyc(1);
    rx_data = 10'h0A2; cyc(1);
    rx_strobe = 1'b0; enable = 1'b0; cyc(1);
    checks++; if (rx_reset !== 1'b1) begin errors++; $display("FAIL dis_rx_reset got %b exp 1", rx_reset); end
    checks++; if (empty !== 1'b0 || rd_data !== 12'h0A1) begin errors++; $display("FAIL dis_kept got %b/%h exp 0/0A1", empty, rd_data); end
    rx_active = 1'b0; cyc(3);
    enable = 1'b1; cyc(1);
    checks++; if (rx_reset !== 1'b0) begin errors++; $display("FAIL reen_rx_reset got %b exp 0", rx_reset); end
    pop1();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL dis_pending_dropped got empty=%b exp 1", empty); end
    frame1(10'h0A3);
    fc_good++;
    checks++; if (empty !== 1'b0 || rd_data !== 12'h4A3) begin errors++; $display("FAIL reen_frame got %b/%h exp 0/4A3", empty, rd_data); end
    checks++; if (frame_count !== fc_model()) begin errors++; $display("FAIL reen_count got %0d exp %0d", frame_count, fc_model()); end
    pop1();
  endtask

  task automatic test_reset_midframe();
    rx_active = 1'b1; cyc(1);
    rx_strobe = 1'b1; rx_data = 10'h0B1; cyc(1);
    rx_data = 10'h0B2; cyc(1);
    rx_strobe = 1'b0;
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL mid_pre_reset got empty=%b exp 0", empty); end
    reset = 1'b1; #1;
    fc_good = '0;
    checks++; if (rx_reset !== 1'b1 || empty !== 1'b1) begin errors++; $display("FAIL mid_reset got rx_reset=%b empty=%b exp 1 1", rx_reset, empty); end
    checks++; if (full !== 1'b0 || overflow !== 1'b0 || rd_data !== 12'h000) begin errors++; $display("FAIL mid_reset_out got %b %b %h exp 0 0 000", full, overflow, rd_data); end
    checks++; if (frame_count !== 8'd0) begin errors++; $display("FAIL mid_reset_count got %0d exp 0", frame_count); end
    cyc(1);
    reset = 1'b0; rx_active = 1'b0; cyc(1);
    frame1(10'h0B3);
    fc_good++;
    checks++; if (empty !== 1'b0 || rd_data !== 12'h4B3) begin errors++; $display("FAIL mid_after got %b/%h exp 0/4B3", empty, rd_data); end
    checks++; if (frame_count !== fc_model()) begin errors++; $display("FAIL mid_after_count got %0d exp %0d", frame_count, fc_model()); end
    pop1();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mid_drained got empty=%b exp 1", empty); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_error_guard();
    test_overflow();
    test_enable_drop();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
